// File: rtl/saa1099_write_sequencer_if.sv
// Host-request and SAA1099 bus signals of the write sequencer, with host (master) and sequencer (slave) views.
interface saa1099_write_sequencer_if #(
   parameter int DEPTH = 4
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_chip;
   logic [4:0]               req_addr;
   logic [7:0]               req_data;
   logic                     cache_inv;
   logic                     cs0_n;
   logic                     cs1_n;
   logic                     a0;
   logic                     wr_n;
   logic [7:0]               dout;
   logic                     busy;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      output req_valid, req_chip, req_addr, req_data, cache_inv,
      input  req_ready, cs0_n, cs1_n, a0, wr_n, dout, busy, level
   );

   modport slave (
      input  req_valid, req_chip, req_addr, req_data, cache_inv,
      output req_ready, cs0_n, cs1_n, a0, wr_n, dout, busy, level
   );
endinterface

// File: rtl/saa1099_write_sequencer.sv
// Queues host writes and replays them on the shared SAA1099 bus as address/data strobe pairs.
// Bus goes active one edge after a request lands in an idle block; req_ready drops only when the FIFO is full.
module saa1099_write_sequencer #(
   parameter int DEPTH      = 4,
   parameter int HOLD_CYC   = 1,
   parameter int ADDR_CACHE = 1
) (
   input  logic                      clk_sys,
   input  logic                      rst,
   saa1099_write_sequencer_if.slave  bus
);
   localparam int             AW        = $clog2(DEPTH);
   localparam int             LW        = AW + 1;
   localparam logic [LW-1:0]  FULL      = LW'(DEPTH);
   localparam logic [2:0]     HOLD_LAST = 3'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, A_SETUP, A_STB, A_HOLD, D_SETUP, D_STB, D_HOLD
   } state_t;

   logic [13:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level;
   logic           push, pop;

   logic           head_chip, wk_chip, sel_chip;
   logic [4:0]     head_addr, wk_addr, sel_addr;
   logic [7:0]     head_data, wk_data, sel_data;

   logic [1:0]     cache_vld;
   logic [4:0]     cache_addr [2];
   logic           cache_hit, cache_wr;

   state_t         state, state_nxt;
   logic [2:0]     hold_cnt;
   logic           hold_last;

   logic           cs0_n_q, cs1_n_q, a0_q, wr_n_q;
   logic [7:0]     dout_q;
   logic           nxt_cs0_n, nxt_cs1_n, nxt_a0, nxt_wr_n;
   logic [7:0]     nxt_dout;

   assign bus.req_ready = !rst && (level < FULL);
   assign push          = bus.req_valid && bus.req_ready;
   assign {head_chip, head_addr, head_data} = mem[rd_ptr];

   assign cache_hit = (ADDR_CACHE != 0) && cache_vld[head_chip]
                      && (cache_addr[head_chip] == head_addr);
   assign hold_last = (hold_cnt == HOLD_LAST);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      cache_wr  = 1'b0;
      case (state)
         A_SETUP: state_nxt = A_STB;
         A_STB:   state_nxt = A_HOLD;
         A_HOLD:  if (hold_last) begin
                     state_nxt = D_SETUP;
                     cache_wr  = 1'b1;
                  end
         D_SETUP: state_nxt = D_STB;
         D_STB:   state_nxt = D_HOLD;
         D_HOLD:  if (hold_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Issue point: idle, or the final data-hold cycle so queued writes chain without a gap.
      if ((state == IDLE || (state == D_HOLD && hold_last)) && level != '0) begin
         pop       = 1'b1;
         state_nxt = cache_hit ? D_SETUP : A_SETUP;
      end

      sel_chip = pop ? head_chip : wk_chip;
      sel_addr = pop ? head_addr : wk_addr;
      sel_data = pop ? head_data : wk_data;

      nxt_cs0_n = 1'b1;
      nxt_cs1_n = 1'b1;
      nxt_a0    = 1'b0;
      nxt_wr_n  = 1'b1;
      nxt_dout  = 8'h00;
      if (state_nxt != IDLE) begin
         nxt_cs0_n = sel_chip;
         nxt_cs1_n = !sel_chip;
         nxt_wr_n  = !(state_nxt == A_STB || state_nxt == D_STB);
         if (state_nxt inside {A_SETUP, A_STB, A_HOLD}) begin
            nxt_a0   = 1'b1;
            nxt_dout = {3'b000, sel_addr};
         end else begin
            nxt_dout = sel_data;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= {bus.req_chip, bus.req_addr, bus.req_data};
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         hold_cnt      <= 3'd0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         wk_chip       <= 1'b0;
         wk_addr       <= 5'd0;
         wk_data       <= 8'd0;
         cache_vld     <= 2'b00;
         cache_addr[0] <= 5'd0;
         cache_addr[1] <= 5'd0;
         cs0_n_q       <= 1'b1;
         cs1_n_q       <= 1'b1;
         a0_q          <= 1'b0;
         wr_n_q        <= 1'b1;
         dout_q        <= 8'h00;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state_nxt != state) ? 3'd0 : hold_cnt + 3'd1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            wk_chip <= head_chip;
            wk_addr <= head_addr;
            wk_data <= head_data;
         end
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         // A coincident invalidate beats the cache fill from the address phase.
         if (bus.cache_inv)  cache_vld          <= 2'b00;
         else if (cache_wr)  cache_vld[wk_chip] <= 1'b1;
         if (cache_wr) cache_addr[wk_chip] <= wk_addr;
         cs0_n_q <= nxt_cs0_n;
         cs1_n_q <= nxt_cs1_n;
         a0_q    <= nxt_a0;
         wr_n_q  <= nxt_wr_n;
         dout_q  <= nxt_dout;
      end
   end

   assign bus.cs0_n = cs0_n_q;
   assign bus.cs1_n = cs1_n_q;
   assign bus.a0    = a0_q;
   assign bus.wr_n  = wr_n_q;
   assign bus.dout  = dout_q;
   assign bus.level = level;
   assign bus.busy  = (level != '0) || (state != IDLE);
endmodule

// File: tb/tb_saa1099_write_sequencer.sv
// Bench for saa1099_write_sequencer: scoreboarded strobes, cs_n run lengths, corner sequences, HOLD_CYC=3 instance.
module tb_saa1099_write_sequencer;
   logic clk_sys = 1'b0;
   logic rst;
   always #5 clk_sys = ~clk_sys;

   saa1099_write_sequencer_if #(.DEPTH(4)) bus1();
   saa1099_write_sequencer_if #(.DEPTH(4)) bus3();

   saa1099_write_sequencer #(.DEPTH(4), .HOLD_CYC(1), .ADDR_CACHE(1)) dut1 (
      .clk_sys(clk_sys), .rst(rst), .bus(bus1));
   saa1099_write_sequencer #(.DEPTH(4), .HOLD_CYC(3), .ADDR_CACHE(1)) dut3 (
      .clk_sys(clk_sys), .rst(rst), .bus(bus3));

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic chip;
      int   start;
      int   len;
   } run_t;

   typedef struct {
      logic       inv;
      logic       chip;
      logic [4:0] addr;
      logic [7:0] data;
      bit         aphase;
      int         len;
   } vec_t;

   logic [10:0] exp_q[$];
   run_t        runs[$];
   int          stb_cyc[$];
   vec_t        vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   // Bus monitor for dut1: cs_n runs and strobes, strobes scored against exp_q.
   initial begin
      int   cyc;
      logic in_run, run_chip, act_any, act_chip;
      int   run_start;
      logic [10:0] got;
      cyc = 0; in_run = 1'b0; run_chip = 1'b0; run_start = 0;
      forever begin
         @(negedge clk_sys);
         cyc++;
         act_any  = !bus1.cs0_n || !bus1.cs1_n;
         act_chip = bus1.cs0_n;
         if (in_run && (!act_any || act_chip != run_chip)) begin
            runs.push_back('{run_chip, run_start, cyc - run_start});
            in_run = 1'b0;
         end
         if (act_any && !in_run) begin
            in_run = 1'b1; run_chip = act_chip; run_start = cyc;
         end
         if (!rst && !bus1.wr_n) begin
            got = {bus1.cs0_n ^ bus1.cs1_n, act_chip, bus1.a0, bus1.dout};
            stb_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL strobe_unexpected: got 0x%0h required no strobe", got);
            end else begin
               check("strobe", {21'd0, got}, {21'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic push1(input logic chip, input logic [4:0] addr, input logic [7:0] data, input bit aphase);
      int i;
      @(negedge clk_sys);
      bus1.req_valid = 1'b1; bus1.req_chip = chip; bus1.req_addr = addr; bus1.req_data = data;
      i = 0;
      while (!bus1.req_ready && i < 300) begin
         @(negedge clk_sys);
         i++;
      end
      if (!bus1.req_ready) begin
         check("push_timeout", {31'd0, bus1.req_ready}, 32'd1);
         bus1.req_valid = 1'b0;
         return;
      end
      if (aphase) exp_q.push_back({1'b1, chip, 1'b1, 3'b000, addr});
      exp_q.push_back({1'b1, chip, 1'b0, data});
      @(posedge clk_sys);
      #1 bus1.req_valid = 1'b0;
   endtask

   task automatic wait_idle1();
      int i;
      i = 0;
      @(negedge clk_sys);
      while (bus1.busy && i < 300) begin
         @(negedge clk_sys);
         i++;
      end
      check("idle_timeout", {31'd0, bus1.busy}, 32'd0);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic pulse_inv1();
      @(negedge clk_sys);
      bus1.cache_inv = 1'b1;
      @(posedge clk_sys);
      #1 bus1.cache_inv = 1'b0;
   endtask

   task automatic expect_run(input string tag, input logic chip, input int len, output int start);
      run_t r;
      start = -1;
      if (runs.size() == 0) begin
         n_checks++;
         $display("FAIL %s_run: got no cs_n run, required chip %0d for %0d cycles", tag, chip, len);
      end else begin
         r = runs.pop_front();
         check({tag, "_chip"}, {31'd0, r.chip}, {31'd0, chip});
         check({tag, "_len"}, r.len, len);
         start = r.start;
      end
   endtask

   task automatic drained(input string tag);
      check({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic push3(input logic chip, input logic [4:0] addr, input logic [7:0] data);
      int i;
      @(negedge clk_sys);
      bus3.req_valid = 1'b1; bus3.req_chip = chip; bus3.req_addr = addr; bus3.req_data = data;
      i = 0;
      while (!bus3.req_ready && i < 300) begin
         @(negedge clk_sys);
         i++;
      end
      check("push3_ready", {31'd0, bus3.req_ready}, 32'd1);
      @(posedge clk_sys);
      #1 bus3.req_valid = 1'b0;
   endtask

   task automatic measure3(output int len, output int nstb, output int off0, output int off1,
                           output logic [8:0] v0, output logic [8:0] v1);
      len = 0; nstb = 0; off0 = -1; off1 = -1; v0 = '0; v1 = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_sys);
         if (!bus3.cs0_n) begin
            if (!bus3.wr_n) begin
               if (nstb == 0) begin off0 = len; v0 = {bus3.a0, bus3.dout}; end
               else begin off1 = len; v1 = {bus3.a0, bus3.dout}; end
               nstb++;
            end
            len++;
         end else if (len > 0) begin
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, s0, s1, len, nstb, off0, off1, found;
      logic [8:0] v0, v1;
      string tag;

      vecs[0] = '{1'b0, 1'b0, 5'h18, 8'h82, 1'b1, 6};
      vecs[1] = '{1'b0, 1'b0, 5'h18, 8'h83, 1'b0, 3};
      vecs[2] = '{1'b0, 1'b1, 5'h18, 8'h84, 1'b1, 6};
      vecs[3] = '{1'b0, 1'b0, 5'h08, 8'h01, 1'b1, 6};
      vecs[4] = '{1'b1, 1'b0, 5'h08, 8'h02, 1'b1, 6};
      vecs[5] = '{1'b0, 1'b0, 5'h08, 8'h03, 1'b0, 3};
      vecs[6] = '{1'b0, 1'b1, 5'h18, 8'h05, 1'b1, 6};
      vecs[7] = '{1'b0, 1'b1, 5'h1F, 8'hFF, 1'b1, 6};
      vecs[8] = '{1'b0, 1'b1, 5'h1F, 8'h00, 1'b0, 3};

      bus1.req_valid = 1'b0; bus1.req_chip = 1'b0; bus1.req_addr = 5'd0; bus1.req_data = 8'd0; bus1.cache_inv = 1'b0;
      bus3.req_valid = 1'b0; bus3.req_chip = 1'b0; bus3.req_addr = 5'd0; bus3.req_data = 8'd0; bus3.cache_inv = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_cs0_n", {31'd0, bus1.cs0_n}, 32'd1);
      check("rst_cs1_n", {31'd0, bus1.cs1_n}, 32'd1);
      check("rst_wr_n", {31'd0, bus1.wr_n}, 32'd1);
      check("rst_a0", {31'd0, bus1.a0}, 32'd0);
      check("rst_dout", {24'd0, bus1.dout}, 32'd0);
      check("rst_busy", {31'd0, bus1.busy}, 32'd0);
      check("rst_level", {29'd0, bus1.level}, 32'd0);
      check("rst_ready", {31'd0, bus1.req_ready}, 32'd0);
      check("rst3_cs0_n", {31'd0, bus3.cs0_n}, 32'd1);
      check("rst3_wr_n", {31'd0, bus3.wr_n}, 32'd1);
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;
      repeat (2) @(negedge clk_sys);

      for (int k = 0; k < 9; k++) begin
         if (vecs[k].inv) pulse_inv1();
         stb_cyc.delete();
         push1(vecs[k].chip, vecs[k].addr, vecs[k].data, vecs[k].aphase);
         wait_idle1();
         tag = $sformatf("vec%0d", k);
         expect_run(tag, vecs[k].chip, vecs[k].len, st);
         check({tag, "_nstb"}, stb_cyc.size(), vecs[k].aphase ? 32'd2 : 32'd1);
         if (stb_cyc.size() > 0) check({tag, "_stb0_at"}, stb_cyc[0] - st, 32'd1);
         if (vecs[k].aphase && stb_cyc.size() > 1) check({tag, "_stb1_at"}, stb_cyc[1] - st, 32'd4);
         drained(tag);
      end

      // Same-register pair on one chip: second write skips the address phase, no gap.
      push1(1'b0, 5'h00, 8'h11, 1'b1);
      push1(1'b0, 5'h00, 8'h22, 1'b0);
      wait_idle1();
      expect_run("seqA", 1'b0, 9, st);
      drained("seqA");

      // Same register on different chips: independent caches, direct chip switch.
      push1(1'b0, 5'h05, 8'hAA, 1'b1);
      push1(1'b1, 5'h05, 8'hBB, 1'b1);
      wait_idle1();
      expect_run("seqB0", 1'b0, 6, s0);
      expect_run("seqB1", 1'b1, 6, s1);
      check("seqB_switch", s1, s0 + 6);
      drained("seqB");

      // Fill the FIFO while the first write is on the bus.
      for (int k = 0; k < 5; k++) push1(1'b1, 5'(5'h10 + k), 8'(8'h30 + k), 1'b1);
      @(negedge clk_sys);
      check("seqC_level_full", {29'd0, bus1.level}, 32'd4);
      check("seqC_ready_full", {31'd0, bus1.req_ready}, 32'd0);
      push1(1'b1, 5'h15, 8'h35, 1'b1);
      wait_idle1();
      expect_run("seqC", 1'b1, 36, st);
      drained("seqC");

      // cache_inv on the A_HOLD exit edge must leave the cache invalid.
      push1(1'b0, 5'h08, 8'h44, 1'b1);
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge clk_sys);
         if (!bus1.wr_n && bus1.a0) found = 1;
      end
      check("seqD_astb_seen", found, 1);
      @(posedge clk_sys);
      #1 bus1.cache_inv = 1'b1;
      @(posedge clk_sys);
      #1 bus1.cache_inv = 1'b0;
      wait_idle1();
      expect_run("seqD1", 1'b0, 6, st);
      push1(1'b0, 5'h08, 8'h45, 1'b1);
      wait_idle1();
      expect_run("seqD2", 1'b0, 6, st);
      drained("seqD");

      // Reset during D_STB with two writes still queued.
      push1(1'b0, 5'h0A, 8'h01, 1'b1);
      push1(1'b0, 5'h0A, 8'h02, 1'b0);
      push1(1'b0, 5'h0A, 8'h03, 1'b0);
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge clk_sys);
         if (!bus1.wr_n && !bus1.a0) found = 1;
      end
      check("seqE_dstb_seen", found, 1);
      check("seqE_level_before", {29'd0, bus1.level}, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("seqE_wr_n", {31'd0, bus1.wr_n}, 32'd1);
      check("seqE_cs0_n", {31'd0, bus1.cs0_n}, 32'd1);
      check("seqE_cs1_n", {31'd0, bus1.cs1_n}, 32'd1);
      check("seqE_level", {29'd0, bus1.level}, 32'd0);
      check("seqE_busy", {31'd0, bus1.busy}, 32'd0);
      check("seqE_ready", {31'd0, bus1.req_ready}, 32'd0);
      @(negedge clk_sys);
      #1;
      exp_q.delete(); runs.delete(); stb_cyc.delete();
      @(negedge clk_sys);
      rst = 1'b0;
      check("seqE_quiet", {31'd0, bus1.wr_n}, 32'd1);
      push1(1'b0, 5'h0A, 8'h04, 1'b1);
      wait_idle1();
      expect_run("seqE_after", 1'b0, 6, st);
      drained("seqE");

      // HOLD_CYC=3 instance: full write, then a cache hit.
      push3(1'b0, 5'h18, 8'h82);
      measure3(len, nstb, off0, off1, v0, v1);
      check("h3_full_len", len, 10);
      check("h3_full_nstb", nstb, 2);
      check("h3_full_stb0_at", off0, 1);
      check("h3_full_stb1_at", off1, 6);
      check("h3_full_addr", {23'd0, v0}, {23'd0, 9'h118});
      check("h3_full_data", {23'd0, v1}, {23'd0, 9'h082});
      check("h3_cs1_idle", {31'd0, bus3.cs1_n}, 32'd1);
      repeat (2) @(negedge clk_sys);
      check("h3_idle", {31'd0, bus3.busy}, 32'd0);
      push3(1'b0, 5'h18, 8'h83);
      measure3(len, nstb, off0, off1, v0, v1);
      check("h3_hit_len", len, 5);
      check("h3_hit_nstb", nstb, 1);
      check("h3_hit_stb0_at", off0, 1);
      check("h3_hit_data", {23'd0, v0}, {23'd0, 9'h083});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/saa1099_write_sequencer.md
Name: saa1099_write_sequencer

Overview:
Buffers host register writes destined for a pair of SAA1099 sound generators, as used in a CMS / Game Blaster board.
Serialises each write onto the chips' shared bus as an address-phase strobe followed by a data-phase strobe, with the setup, strobe and hold spacing the chip's edge-detecting write port requires.
Keeps a per-chip cache of the last address written, so that repeated writes to the same register skip the address phase.
Sits between the host bus decoder and the two saa1099 instances.

Parameters:
DEPTH, 4, request FIFO entries (power of two, 2..16)
HOLD_CYC, 1, cycles cs_n/a0/dout remain stable after wr_n returns high (1..7)
ADDR_CACHE, 1, 1 = skip the address phase on a cache hit; 0 = always issue the address phase

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  host write request
req_ready  out  1  FIFO can accept (count < DEPTH)
req_chip  in  1  0 = chip 0, 1 = chip 1
req_addr  in  5  SAA1099 register index
req_data  in  8  register data
cache_inv  in  1  invalidate both address caches (pulse)
cs0_n  out  1  chip 0 select
cs1_n  out  1  chip 1 select
a0  out  1  1 = address phase, 0 = data phase
wr_n  out  1  write strobe
dout  out  8  bus data to the chips
busy  out  1  FIFO non-empty or FSM not IDLE
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; level=0; req_ready=0 while rst=1.
  - State goes to IDLE; both cache valid bits cleared.
  - Outputs: cs0_n=1, cs1_n=1, wr_n=1, a0=0, dout=0x00, busy=0.
  - Reset mid-operation abandons the write in progress with no further strobe.
- All bus outputs are registered and decoded from the next state, so the bus is glitch-free.
- FIFO:
  - A push occurs on an edge where req_valid & req_ready.
  - req_ready = (level < DEPTH); it does not look ahead to a same-cycle pop.
  - Push and pop on the same edge leave level unchanged.
  - Entries are stored as {chip, addr, data} and issued strictly in order.
- States: IDLE, A_SETUP, A_STB, A_HOLD, D_SETUP, D_STB, D_HOLD.
- Issue decision, made on any edge in IDLE, or on the last D_HOLD cycle, when the FIFO is non-empty:
  - Pop the head into a working register.
  - Next state is D_SETUP if ADDR_CACHE=1, the cache for that chip is valid, and the cached address equals the head address. Otherwise next state is A_SETUP.
- Bus values per state:
  - A_SETUP: cs_n(chip)=0, a0=1, dout={3'b0, addr}, wr_n=1. Lasts 1 cycle.
  - A_STB: same values except wr_n=0. Lasts exactly 1 cycle.
  - A_HOLD: wr_n=1, with cs_n, a0 and dout unchanged. Lasts HOLD_CYC cycles, counted by a 3-bit counter.
  - On leaving A_HOLD: cache[chip] ← {valid, addr}; next state D_SETUP.
  - D_SETUP, D_STB, D_HOLD: as the A states but with a0=0 and dout=data.
  - After D_HOLD: pop the next entry if one is available, otherwise go to IDLE.
  - In IDLE: both cs_n=1 and wr_n=1.
- The non-selected chip's cs_n stays at 1 throughout.
- wr_n is high for at least HOLD_CYC+1 cycles between consecutive strobes, which guarantees the chip sees a fresh falling edge.
- Latency and cycle counts:
  - A request accepted at edge E0 into an empty, idle block appears on the bus (cs_n low) after E1.
  - cs_n is low for 6+2*HOLD_CYC-2 cycles with an address phase, or 2+HOLD_CYC cycles on a cache hit.
  - With HOLD_CYC=1 that is 6 and 3 cycles respectively.
- Back-to-back writes:
  - No IDLE gap between writes.
  - cs_n may switch chips directly between D_HOLD and the next SETUP.
- cache_inv:
  - Clears both valid bits on the edge where it is asserted.
  - If it coincides with the A_HOLD exit, invalidation wins and the valid bit is left clear.
  - It does not affect the write in progress.
- busy = (level != 0) | (state != IDLE).

Test Plan:
- Push chip0/addr 0x18/data 0x82 into an idle block.
  → cs0_n low 6 cycles.
  → a0=1, dout=0x18, wr_n low in cycle 2.
  → a0=0, dout=0x82, wr_n low in cycle 5.
  → cs1_n=1 throughout; busy drops after the last hold.
- Push chip0 0x00/0x11 then chip0 0x00/0x22.
  → the second write has no address phase: 3 cycles, one strobe with a0=0, dout=0x22.
  → no IDLE between the two writes.
- Push chip0 0x05/0xAA then chip1 0x05/0xBB.
  → chip1 issues a full address phase, because the caches are independent.
  → cs0_n rises in the same edge cs1_n falls.
- Push 5 requests back-to-back while the first is issuing.
  → req_ready=0 when level=4; the 5th is held until a pop.
  → the bus order of (addr, data) matches push order.
- Write chip0 0x08, pulse cache_inv, then write chip0 0x08 again.
  → the address phase is reissued.
  → repeat with cache_inv on the A_HOLD exit edge: the next same-address write still gets an address phase.
- Assert rst during D_STB with 2 entries queued.
  → same cycle: wr_n=1, cs0_n=cs1_n=1, level=0, busy=0.
  → after release, a new write issues a full address phase.
  → run again with HOLD_CYC=3 and confirm the 3-cycle holds.
